// File: rtl/pistorm16_bus_pkg.sv
// Shared types and constants for the PiStorm16 Amiga-side bus logic.
package pistorm16_bus_pkg;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FC_W   = 3;
    localparam int unsigned TMO_W  = 16;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        S0,
        S2,
        S4,
        S6,
        S7
    } bus_state_e;

    // 68000 function-code encodings
    localparam logic [FC_W-1:0] USER_DATA  = 3'b001;
    localparam logic [FC_W-1:0] USER_PROG  = 3'b010;
    localparam logic [FC_W-1:0] SUPER_DATA = 3'b101;
    localparam logic [FC_W-1:0] SUPER_PROG = 3'b110;
    localparam logic [FC_W-1:0] CPU_SPACE  = 3'b111;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [FC_W-1:0]   fc;
        logic              rnw;
        logic              uds;
        logic              lds;
    } bus_req_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for raw asynchronous bus inputs (DTACK, BERR, IPL, VPA).
module sync2 #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RESET) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/m68k_bus_cycle_sequencer.sv
// Runs one 68000 asynchronous bus cycle (S0..S7) on MC_CLK edge strobes,
// driving address/data/FC/strobes and terminating on DTACK, BERR or timeout.
module m68k_bus_cycle_sequencer
    import pistorm16_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RESET,
    input  logic              mc_rise,
    input  logic              mc_fall,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_rnw,
    input  logic              req_uds,
    input  logic              req_lds,
    input  logic [FC_W-1:0]   req_fc,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_berr,
    input  logic              nDTACK,
    input  logic              nBERR,
    input  logic [DATA_W-1:0] D_IN,
    output logic [ADDR_W-1:0] A_OUT,
    output logic              A_DRIVE,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_DRIVE,
    output logic [FC_W-1:0]   FC_OUT,
    output logic              FC_DRIVE,
    output logic              RnW_OUT,
    output logic              nAS_OUT,
    output logic              nUDS_OUT,
    output logic              nLDS_OUT,
    output logic              busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              berr_q, berr_d;

    logic              req_ready_d, busy_d, resp_valid_d, resp_berr_d;
    logic [DATA_W-1:0] resp_rdata_d, d_out_d;
    logic [ADDR_W-1:0] a_out_d;
    logic [FC_W-1:0]   fc_out_d;
    logic              a_drive_d, d_drive_d, fc_drive_d, rnw_out_d;
    logic              nas_d, nuds_d, nlds_d;

    logic [1:0]        term_sync;
    logic              ndtack_s, nberr_s;

    sync2 #(
        .WIDTH     (2),
        .RESET_VAL (2'b11)
    ) u_term_sync (
        .SYS_CLK   (SYS_CLK),
        .SYS_RESET (SYS_RESET),
        .d         ({nBERR, nDTACK}),
        .q         (term_sync)
    );

    assign nberr_s  = term_sync[1];
    assign ndtack_s = term_sync[0];

    // Next-state and next-output decode; everything holds unless a strobe moves it
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        berr_d       = berr_q;
        resp_valid_d = 1'b0;
        resp_berr_d  = resp_berr;
        resp_rdata_d = resp_rdata;
        a_out_d      = A_OUT;
        a_drive_d    = A_DRIVE;
        d_out_d      = D_OUT;
        d_drive_d    = D_DRIVE;
        fc_out_d     = FC_OUT;
        fc_drive_d   = FC_DRIVE;
        rnw_out_d    = RnW_OUT;
        nas_d        = nAS_OUT;
        nuds_d       = nUDS_OUT;
        nlds_d       = nLDS_OUT;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.fc    = req_fc;
                    req_d.rnw   = req_rnw;
                    req_d.uds   = req_uds;
                    req_d.lds   = req_lds;
                    cnt_d       = '0;
                    berr_d      = 1'b0;
                    state_d     = ARM;
                end
            end
            ARM: begin
                a_out_d    = req_q.addr;
                fc_out_d   = req_q.fc;
                rnw_out_d  = req_q.rnw;
                a_drive_d  = 1'b1;
                fc_drive_d = 1'b1;
                if (mc_rise) begin
                    state_d = S0;
                end
            end
            S0: begin
                if (mc_fall) begin
                    nas_d = 1'b0;
                    if (req_q.rnw) begin
                        nuds_d = ~req_q.uds;
                        nlds_d = ~req_q.lds;
                    end else begin
                        d_out_d   = req_q.wdata;
                        d_drive_d = 1'b1;
                    end
                    state_d = S2;
                end
            end
            S2: begin
                if (mc_rise) begin
                    if (!req_q.rnw) begin
                        nuds_d = ~req_q.uds;
                        nlds_d = ~req_q.lds;
                    end
                    state_d = S4;
                end
            end
            S4: begin
                // BERR beats DTACK; DTACK beats the timeout on the final wait state
                if (mc_fall) begin
                    if (!nberr_s || (ndtack_s && (cnt_q == TMO_LAST))) begin
                        berr_d       = 1'b1;
                        resp_rdata_d = '0;
                        nas_d        = 1'b1;
                        nuds_d       = 1'b1;
                        nlds_d       = 1'b1;
                        state_d      = S7;
                    end else if (!ndtack_s) begin
                        state_d = S6;
                    end else begin
                        cnt_d = cnt_q + TMO_W'(1);
                    end
                end
            end
            S6: begin
                if (mc_fall) begin
                    resp_rdata_d = req_q.rnw ? D_IN : '0;
                    nas_d        = 1'b1;
                    nuds_d       = 1'b1;
                    nlds_d       = 1'b1;
                    state_d      = S7;
                end
            end
            S7: begin
                if (mc_rise) begin
                    a_drive_d    = 1'b0;
                    d_drive_d    = 1'b0;
                    fc_drive_d   = 1'b0;
                    rnw_out_d    = 1'b1;
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_berr_d  = berr_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE) && !resp_valid_d;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RESET) begin
            state_q    <= IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            berr_q     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_berr  <= 1'b0;
            resp_rdata <= '0;
            A_OUT      <= '0;
            A_DRIVE    <= 1'b0;
            D_OUT      <= '0;
            D_DRIVE    <= 1'b0;
            FC_OUT     <= '0;
            FC_DRIVE   <= 1'b0;
            RnW_OUT    <= 1'b1;
            nAS_OUT    <= 1'b1;
            nUDS_OUT   <= 1'b1;
            nLDS_OUT   <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            berr_q     <= berr_d;
            req_ready  <= req_ready_d;
            busy       <= busy_d;
            resp_valid <= resp_valid_d;
            resp_berr  <= resp_berr_d;
            resp_rdata <= resp_rdata_d;
            A_OUT      <= a_out_d;
            A_DRIVE    <= a_drive_d;
            D_OUT      <= d_out_d;
            D_DRIVE    <= d_drive_d;
            FC_OUT     <= fc_out_d;
            FC_DRIVE   <= fc_drive_d;
            RnW_OUT    <= rnw_out_d;
            nAS_OUT    <= nas_d;
            nUDS_OUT   <= nuds_d;
            nLDS_OUT   <= nlds_d;
        end
    end

endmodule

// File: tb/tb_m68k_bus_cycle_sequencer.sv
// Scoreboard bench: a driver issues bus requests, a negedge monitor checks each response
// and the strobe timeline against an event-count model of the 68000 bus cycle.
module tb_m68k_bus_cycle_sequencer;
    import pistorm16_bus_pkg::*;

    localparam int TO     = 4;
    localparam int HALF   = 4;
    localparam int NO_ACK = 99;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RESET = 1'b1;
    logic        mc_rise = 1'b0, mc_fall = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [22:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_rnw = 1'b1, req_uds = 1'b0, req_lds = 1'b0;
    logic [2:0]  req_fc = '0;
    logic        resp_valid, resp_berr;
    logic [15:0] resp_rdata;
    logic        nDTACK = 1'b1, nBERR = 1'b1;
    logic [15:0] D_IN = '0;
    logic [22:0] A_OUT;
    logic [15:0] D_OUT;
    logic [2:0]  FC_OUT;
    logic        A_DRIVE, D_DRIVE, FC_DRIVE, RnW_OUT, nAS_OUT, nUDS_OUT, nLDS_OUT, busy;

    m68k_bus_cycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RESET(SYS_RESET), .mc_rise(mc_rise), .mc_fall(mc_fall),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rnw(req_rnw), .req_uds(req_uds), .req_lds(req_lds),
        .req_fc(req_fc), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_berr(resp_berr), .nDTACK(nDTACK), .nBERR(nBERR), .D_IN(D_IN),
        .A_OUT(A_OUT), .A_DRIVE(A_DRIVE), .D_OUT(D_OUT), .D_DRIVE(D_DRIVE),
        .FC_OUT(FC_OUT), .FC_DRIVE(FC_DRIVE), .RnW_OUT(RnW_OUT), .nAS_OUT(nAS_OUT),
        .nUDS_OUT(nUDS_OUT), .nLDS_OUT(nLDS_OUT), .busy(busy)
    );

    typedef struct {
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [2:0]  fc;
        logic        rnw, uds, lds;
        int          w;
        bit          berr, b2b;
        logic [15:0] exp_rdata;
        logic        exp_berr;
        int          exp_neg_h, exp_done_h;
    } txn_t;

    txn_t exp_q[$];
    txn_t plan[$];
    txn_t cur;

    int total = 0, bad = 0;
    int issued = 0, acc_n = 0, resp_seen = 0;
    int cyc = 0, acc_cyc = 0, last_resp_cyc = -100;
    int rise_cnt = 0, fall_cnt = 0;
    bit in_flight = 0;
    int as_low_h, as_high_h, uds_low_h, lds_low_h, dd_h;
    bit bus_bad;

    initial forever #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model in bus-event terms: h counts MC edges (rise1=1, fall1=2, ...)
    // seen after acceptance; S4 first samples on fall 2.
    function automatic txn_t model(input txn_t t);
        int  f_exit;
        bit  ok;
        if (t.berr) begin
            ok = 0; f_exit = 2;
        end else if (t.w < TO) begin
            ok = 1; f_exit = 2 + t.w;
        end else begin
            ok = 0; f_exit = TO + 1;
        end
        t.exp_berr   = !ok;
        t.exp_rdata  = (ok && t.rnw) ? t.din : 16'h0000;
        t.exp_neg_h  = ok ? 2 * (f_exit + 1) : 2 * f_exit;
        t.exp_done_h = t.exp_neg_h + 1;
        return t;
    endfunction

    function automatic txn_t mk(input logic [22:0] a, input logic [2:0] fc, input logic rnw,
                                input logic uds, input logic lds, input logic [15:0] wd,
                                input logic [15:0] din, input int w, input bit be, input bit b2b);
        txn_t t;
        t.addr = a; t.fc = fc; t.rnw = rnw; t.uds = uds; t.lds = lds;
        t.wdata = wd; t.din = din; t.w = w; t.berr = be; t.b2b = b2b;
        t.exp_rdata = '0; t.exp_berr = 1'b0; t.exp_neg_h = 0; t.exp_done_h = 0;
        return t;
    endfunction

    // MC_CLK edge strobes: one rise and one fall per 2*HALF SYS_CLKs
    initial begin
        int phase = 0;
        forever begin
            @(posedge SYS_CLK); #1;
            phase   = (phase + 1) % (2 * HALF);
            mc_rise = (phase == 0);
            mc_fall = (phase == HALF);
        end
    end

    // Bus slave: data, DTACK after the programmed wait states, or BERR with DTACK
    initial forever begin
        @(posedge SYS_CLK); #1;
        D_IN = in_flight ? cur.din : 16'($urandom);
        if (in_flight && cur.berr) begin
            nBERR = 1'b0; nDTACK = 1'b0;
        end else if (in_flight && cur.w < TO && fall_cnt >= 1 + cur.w) begin
            nBERR = 1'b1; nDTACK = 1'b0;
        end else begin
            nBERR = 1'b1; nDTACK = 1'b1;
        end
    end

    // Monitor and scoreboard
    always @(negedge SYS_CLK) begin : mon
        int   h;
        txn_t e;
        cyc++;
        if (SYS_RESET) begin
            if (in_flight && exp_q.size() > 0) void'(exp_q.pop_front());
            in_flight = 0;
            rise_cnt = 0; fall_cnt = 0;
        end else begin
            h = rise_cnt + fall_cnt;
            if (in_flight) begin
                if (!nAS_OUT && as_low_h < 0) as_low_h = h;
                if (nAS_OUT && as_low_h >= 0 && as_high_h < 0) as_high_h = h;
                if (!nUDS_OUT && uds_low_h < 0) uds_low_h = h;
                if (!nLDS_OUT && lds_low_h < 0) lds_low_h = h;
                if (D_DRIVE && dd_h < 0) dd_h = h;
                if (A_DRIVE && (A_OUT != cur.addr || FC_OUT != cur.fc || RnW_OUT != cur.rnw)) bus_bad = 1;
                if (D_DRIVE && (cur.rnw || D_OUT != cur.wdata)) bus_bad = 1;
                if (cyc - acc_cyc > 1000) begin
                    chk("watchdog_resp", 1, 0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    in_flight = 0;
                end
            end
            if (resp_valid) begin
                resp_seen++;
                if (!in_flight || exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    in_flight = 0;
                    last_resp_cyc = cyc;
                    chk("rdata", resp_rdata, e.exp_rdata);
                    chk("berr", resp_berr, e.exp_berr);
                    chk("resp_edge", h, e.exp_done_h);
                    chk("as_assert_edge", as_low_h, 2);
                    chk("as_negate_edge", as_high_h, e.exp_neg_h);
                    chk("uds_assert_edge", uds_low_h, e.uds ? (e.rnw ? 2 : 3) : -1);
                    chk("lds_assert_edge", lds_low_h, e.lds ? (e.rnw ? 2 : 3) : -1);
                    chk("ddrive_edge", dd_h, e.rnw ? -1 : 2);
                    chk("bus_values", bus_bad, 0);
                    chk("released_at_resp",
                        {A_DRIVE, D_DRIVE, FC_DRIVE, RnW_OUT, nAS_OUT, nUDS_OUT, nLDS_OUT, req_ready, busy},
                        9'b000_1_111_0_0);
                end
            end
            if (in_flight) begin
                if (mc_rise) rise_cnt++;
                if (mc_fall && rise_cnt > 0) fall_cnt++;
            end
            if (req_valid && req_ready) begin
                if (exp_q.size() == 0) begin
                    chk("accept_without_stimulus", 1, 0);
                end else begin
                    cur = exp_q[0];
                    if (cur.b2b) chk("b2b_gap", cyc - last_resp_cyc, 1);
                end
                in_flight = 1;
                acc_n++;
                acc_cyc = cyc;
                rise_cnt = 0; fall_cnt = 0;
                as_low_h = -1; as_high_h = -1; uds_low_h = -1; lds_low_h = -1; dd_h = -1;
                bus_bad = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge SYS_CLK); #1; end
    endtask

    task automatic issue(input txn_t t);
        exp_q.push_back(model(t));
        req_addr = t.addr; req_wdata = t.wdata; req_rnw = t.rnw;
        req_uds = t.uds; req_lds = t.lds; req_fc = t.fc;
        req_valid = 1'b1;
        issued++;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (acc_n != issued && n < 400) begin tick(1); n++; end
        chk("accepted", acc_n, issued);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((in_flight || exp_q.size() != 0) && n < 2000) begin tick(1); n++; end
        chk("drained", (in_flight || exp_q.size() != 0), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctl"},
            {nAS_OUT, nUDS_OUT, nLDS_OUT, RnW_OUT, A_DRIVE, D_DRIVE, FC_DRIVE, req_ready, busy, resp_valid},
            10'b1111_000_1_0_0);
        chk({tag, "_data"}, {A_OUT, D_OUT, FC_OUT, resp_rdata, resp_berr}, '0);
    endtask

    initial begin
        txn_t t;
        int   r, seen, n;

        tick(4);
        @(negedge SYS_CLK);
        chk_reset_state("reset");
        @(posedge SYS_CLK); #1;
        SYS_RESET = 1'b0;

        plan.push_back(mk(23'h07E000, SUPER_DATA, 1, 1, 1, 16'h0000, 16'hBEEF, 0, 0, 0));
        plan.push_back(mk(23'h012345, USER_DATA, 0, 1, 0, 16'h5A00, 16'h1111, 0, 0, 0));
        plan.push_back(mk(23'h000400, USER_PROG, 1, 1, 1, 16'h0000, 16'hC0DE, 3, 0, 0));
        plan.push_back(mk(23'h7FFFFF, SUPER_PROG, 1, 1, 1, 16'h0000, 16'h2222, 0, 1, 0));
        plan.push_back(mk(23'h100000, USER_DATA, 1, 1, 1, 16'h0000, 16'h3333, NO_ACK, 0, 0));
        plan.push_back(mk(23'h0000FF, CPU_SPACE, 1, 0, 0, 16'h0000, 16'h4444, 1, 0, 0));
        plan.push_back(mk(23'h055AA5, SUPER_DATA, 0, 1, 1, 16'hA5C3, 16'h5555, 0, 0, 0));
        plan.push_back(mk(23'h055AA6, SUPER_DATA, 1, 0, 1, 16'h0000, 16'h9876, 2, 0, 1));
        for (int i = 0; i < 30; i++) begin
            t = mk(23'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), 0, 0, bit'($urandom_range(0, 1)));
            r = $urandom_range(0, 9);
            if (r < 6)      t.w = $urandom_range(0, TO - 1);
            else if (r < 8) t.berr = 1;
            else            t.w = NO_ACK;
            plan.push_back(t);
        end

        for (int i = 0; i < plan.size(); i++) begin
            if (!plan[i].b2b) begin
                req_valid = 1'b0;
                wait_idle();
                tick($urandom_range(0, 5));
            end
            issue(plan[i]);
            wait_accept();
        end
        req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of an S4 wait state
        issue(mk(23'h0ABCDE, USER_DATA, 1, 1, 1, 16'h0000, 16'h7777, NO_ACK, 0, 0));
        wait_accept();
        req_valid = 1'b0;
        n = 0;
        while (fall_cnt < 3 && n < 500) begin tick(1); n++; end
        chk("reached_s4", fall_cnt >= 3, 1);
        seen = resp_seen;
        SYS_RESET = 1'b1;
        tick(1);
        SYS_RESET = 1'b0;
        @(negedge SYS_CLK);
        chk_reset_state("midcycle_reset");
        tick(80);
        chk("no_resp_after_reset", resp_seen - seen, 0);

        issue(mk(23'h000002, USER_DATA, 1, 1, 1, 16'h0000, 16'h600D, 0, 0, 0));
        wait_accept();
        req_valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
